// File: rtl/neonfox_pkg.sv
// Shared NeonFox PC-path types: return-address stack op decode and checkpoint record.
// The checkpoint record is sized for the widest supported stack (64-bit addresses, 256 entries).
package neonfox_pkg;

    typedef enum logic [1:0] {
        RAS_NOP  = 2'b00,
        RAS_PUSH = 2'b01,
        RAS_POP  = 2'b10,
        RAS_REPL = 2'b11
    } ras_op_e;

    localparam int RAS_SNAP_DATA_W = 64;
    localparam int RAS_SNAP_PTR_W  = 8;
    localparam int RAS_SNAP_CNT_W  = 9;

    typedef struct packed {
        logic [RAS_SNAP_PTR_W-1:0]  wr_ptr;
        logic [RAS_SNAP_CNT_W-1:0]  count;
        logic [RAS_SNAP_DATA_W-1:0] top;
    } ras_snap_t;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        ras_op_e op;
        unique case ({pop, push})
            2'b01:   op = RAS_PUSH;
            2'b10:   op = RAS_POP;
            2'b11:   op = RAS_REPL;
            default: op = RAS_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Bus between the PC logic (master) and the return-address stack (slave).
interface ret_addr_stack_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              en;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              flush;
    logic              clr_err;
    logic              snap;
    logic              restore;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output en, push, pop, push_data, flush, clr_err, snap, restore,
        input  top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  en, push, pop, push_data, flush, clr_err, snap, restore,
        output top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ras_mem.sv
// Backing store for the older return-address stack entries; one write port, async read.
module ras_mem #(
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 15,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    (* ramstyle = "logic" *) logic [DATA_W-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: registered top-of-stack plus circular memory for older entries.
// Define RAS_SNAPSHOT_EN to build the snap/restore checkpoint for mispredict recovery.
module ret_addr_stack
    import neonfox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic              clk,
    input logic              rst,
    ret_addr_stack_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MEM_N = DEPTH - 1;
    localparam int PTR_W = (MEM_N > 1) ? $clog2(MEM_N) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_N - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              ovf_set, udf_set;
    logic              mem_we;
    logic [PTR_W-1:0]  ptr_nxt, ptr_prv;
    logic [DATA_W-1:0] mem_rdata;
    logic              is_empty, is_full;
    ras_op_e           op;

    assign op       = ras_decode(bus.push, bus.pop);
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_FULL);
    // Explicit wrap so memory depth need not be a power of two
    assign ptr_nxt  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign ptr_prv  = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);

    ras_mem #(
        .DATA_W  (DATA_W),
        .ENTRIES (MEM_N),
        .ADDR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (top_q),
        .raddr_i (ptr_prv),
        .rdata_o (mem_rdata)
    );

`ifdef RAS_SNAPSHOT_EN
    ras_snap_t snap_q, snap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) snap_q <= '0;
        else     snap_q <= snap_d;
    end
`else
    wire unused_snap_ports = bus.snap ^ bus.restore;
`endif

    always_comb begin
        top_d    = top_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        mem_we   = 1'b0;
`ifdef RAS_SNAPSHOT_EN
        snap_d   = snap_q;
`endif
        if (bus.en) begin
            if (bus.flush) begin
                top_d    = '0;
                cnt_d    = '0;
                wr_ptr_d = '0;
            end
`ifdef RAS_SNAPSHOT_EN
            else if (bus.restore) begin
                wr_ptr_d = snap_q.wr_ptr[PTR_W-1:0];
                cnt_d    = snap_q.count[CNT_W-1:0];
                top_d    = snap_q.top[DATA_W-1:0];
            end
`endif
            else begin
                unique case (op)
                    RAS_PUSH, RAS_REPL: begin
                        top_d = bus.push_data;
                        // Simultaneous push/pop on a live stack only swaps the top
                        if (op == RAS_PUSH || is_empty) begin
                            if (!is_empty) begin
                                mem_we   = 1'b1;
                                wr_ptr_d = ptr_nxt;
                            end
                            if (is_full) ovf_set = 1'b1;
                            else         cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    RAS_POP: begin
                        if (is_empty) begin
                            udf_set = 1'b1;
                        end else if (cnt_q == CNT_W'(1)) begin
                            top_d = '0;
                            cnt_d = '0;
                        end else begin
                            wr_ptr_d = ptr_prv;
                            top_d    = mem_rdata;
                            cnt_d    = cnt_q - CNT_W'(1);
                        end
                    end
                    RAS_NOP: ;
                endcase
            end
            if (bus.clr_err) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (ovf_set) ovf_d = 1'b1;
            if (udf_set) udf_d = 1'b1;
`ifdef RAS_SNAPSHOT_EN
            if (bus.snap && !bus.restore) begin
                snap_d.wr_ptr = RAS_SNAP_PTR_W'(wr_ptr_q);
                snap_d.count  = RAS_SNAP_CNT_W'(cnt_q);
                snap_d.top    = RAS_SNAP_DATA_W'(top_q);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            top_q    <= top_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.top       = top_q;
    assign bus.count     = cnt_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed vector bench for ret_addr_stack at DEPTH=4, DATA_W=32.
module tb_ret_addr_stack;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ret_addr_stack_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    ret_addr_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          en, push, pop, flush, clr, snap, rest;
        logic [DW-1:0] data;
        logic [DW-1:0] etop;
        int            ecnt;
        logic          eo, eu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, push, pop, flush, clr,
                                input logic [DW-1:0] data, etop,
                                input int ecnt, input logic eo, eu);
        vec_t v;
        v.en = en; v.push = push; v.pop = pop; v.flush = flush; v.clr = clr;
        v.snap = 1'b0; v.rest = 1'b0;
        v.data = data; v.etop = etop; v.ecnt = ecnt; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.en = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
        bus.clr_err = 1'b0; bus.snap = 1'b0; bus.restore = 1'b0; bus.push_data = '0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] et, input int ec,
                         input logic eo, input logic eu);
        logic ee, ef;
        ee = (ec == 0);
        ef = (ec == DP);
        total++;
        if (bus.top === et && bus.count === 3'(ec) && bus.empty === ee &&
            bus.full === ef && bus.overflow === eo && bus.underflow === eu) begin
            passed++;
        end else begin
            $display("FAIL %s: got top=%h cnt=%0d e=%b f=%b ovf=%b udf=%b, want top=%h cnt=%0d e=%b f=%b ovf=%b udf=%b",
                     name, bus.top, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                     et, ec, ee, ef, eo, eu);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.en = v.en; bus.push = v.push; bus.pop = v.pop; bus.flush = v.flush;
        bus.clr_err = v.clr; bus.snap = v.snap; bus.restore = v.rest; bus.push_data = v.data;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic step(input string name, input vec_t v);
        apply(v);
        check(name, v.etop, v.ecnt, v.eo, v.eu);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        //             en push pop fl clr data  top  cnt ovf udf
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h10, 'h10, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h20, 'h20, 2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h30, 'h30, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h20, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h10, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0A, 'h0A, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0B, 'h0B, 2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0C, 'h0C, 3, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0D, 'h0D, 4, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0E, 'h0E, 4, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h0D, 3, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h0C, 2, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h0B, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h00, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 'h00, 'h00, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h00, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 'h00, 'h00, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h33, 'h33, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h40, 'h40, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h55, 'h55, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h33, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h66, 'h66, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h77, 'h77, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h88, 'h88, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 'h99, 'h88, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 'h00, 'h88, 2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 'h99, 'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h05, 'h05, 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset", '0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Fill to overflow, then hit reset between clock edges
        apply(mk(1, 1, 0, 0, 0, 'h06, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 0, 0, 'h07, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 0, 0, 'h08, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 0, 0, 'h09, 0, 0, 0, 0));
        check("pre_rst", 'h09, 4, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", '0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", mk(1, 1, 0, 0, 0, 'hAB, 'hAB, 1, 0, 0));

`ifdef RAS_SNAPSHOT_EN
        begin
            vec_t v;
            step("snp_flush", mk(1, 0, 0, 1, 0, 'h0, 'h0, 0, 0, 0));
            step("snp_p1",    mk(1, 1, 0, 0, 0, 'h1, 'h1, 1, 0, 0));
            step("snp_p2",    mk(1, 1, 0, 0, 0, 'h2, 'h2, 2, 0, 0));
            v = mk(1, 0, 0, 0, 0, 'h0, 'h2, 2, 0, 0);
            v.snap = 1'b1;
            step("snp_snap",  v);
            step("snp_p3",    mk(1, 1, 0, 0, 0, 'h3, 'h3, 3, 0, 0));
            step("snp_pop1",  mk(1, 0, 1, 0, 0, 'h0, 'h2, 2, 0, 0));
            step("snp_pop2",  mk(1, 0, 1, 0, 0, 'h0, 'h1, 1, 0, 0));
            v = mk(1, 1, 0, 0, 0, 'hF, 'h2, 2, 0, 0);
            v.rest = 1'b1;
            step("snp_rest",  v);
            step("snp_pop3",  mk(1, 0, 1, 0, 0, 'h0, 'h1, 1, 0, 0));
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
